// File: rtl/c3_ctrl_pkg.sv
// Shared constants for the C3 feature-map BRAM control logic.
// Holds the requester ids, the legal read latencies and the round-robin preference type.
package c3_ctrl_pkg;

    localparam logic ID_P0 = 1'b0;
    localparam logic ID_P1 = 1'b1;

    // These latencies match the BRAM RAM_PERFORMANCE setting.
    localparam int RD_LAT_HIGH_PERF = 2;
    localparam int RD_LAT_LOW_LAT   = 1;

    typedef enum logic {
        PREF_P0 = 1'b0,
        PREF_P1 = 1'b1
    } rr_pref_e;

endpackage

// File: rtl/c3_rd_tag_pipe.sv
// Delay line of {valid,id} pairs that follows each read through the BRAM latency.
// Stage 0 is loaded at the accepting edge; the last stage lines up with the BRAM output.
module c3_rd_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_id,
    output logic [DEPTH-1:0] valid,
    output logic             out_id
);

    logic [DEPTH-1:0] id_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            id_sr <= '0;
        end else begin
            valid <= {valid[DEPTH-2:0], in_valid};
            id_sr <= {id_sr[DEPTH-2:0], in_id};
        end
    end

    assign out_id = id_sr[DEPTH-1];

endmodule

// File: rtl/c3_bram_port_arbiter.sv
// Shares BRAM port A between the conv writer/reader (P0) and the pooling reader (P1).
// It uses a round-robin or fixed-priority grant and a registered BRAM drive, and returns read data tagged to its issuer.
module c3_bram_port_arbiter
    import c3_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 18,
    parameter int RD_LAT    = RD_LAT_HIGH_PERF,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_regcea,
    output logic              bram_rsta,
    input  logic [DATA_W-1:0] bram_douta
);

    localparam int DEPTH = RD_LAT + 1;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("c3_bram_port_arbiter: RD_LAT must be 1 or 2, got %0d", RD_LAT);
    end

    rr_pref_e          rr_ptr;
    rr_pref_e          rr_next;
    logic              accept;
    logic              win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DEPTH-1:0]  pipe_valid;
    logic              pipe_out_id;

    // Only a tie consults the preference; a lone requester is always granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRI || rr_ptr == PREF_P0) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (gnt0) begin
            rr_next = PREF_P1;
        end else if (gnt1) begin
            rr_next = PREF_P0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= PREF_P0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    assign accept    = gnt0 | gnt1;
    assign win_id    = gnt1 ? ID_P1 : ID_P0;
    assign win_we    = gnt1 ? we1 : we0;
    assign win_addr  = gnt1 ? addr1 : addr0;
    assign win_wdata = gnt1 ? wdata1 : wdata0;

    // Address and data hold on idle cycles so port A does not toggle needlessly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else begin
            bram_ena <= accept;
            bram_wea <= accept & win_we;
            if (accept) begin
                bram_addra <= win_addr;
                bram_dina  <= win_wdata;
            end
        end
    end

    c3_rd_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept & ~win_we),
        .in_id    (win_id),
        .valid    (pipe_valid),
        .out_id   (pipe_out_id)
    );

    // The BRAM output register must capture exactly one cycle after the array read.
    if (RD_LAT == 2) begin : g_regce
        assign bram_regcea = pipe_valid[1];
    end else begin : g_no_regce
        assign bram_regcea = 1'b0;
    end

    assign rvalid0   = pipe_valid[RD_LAT] & (pipe_out_id == ID_P0);
    assign rvalid1   = pipe_valid[RD_LAT] & (pipe_out_id == ID_P1);
    assign busy      = |pipe_valid;
    assign rdata     = bram_douta;
    assign bram_rsta = rst;

endmodule

// File: tb/tb_c3_bram_port_arbiter.sv
// Bench for c3_bram_port_arbiter: a round-robin DUT with a HIGH_PERFORMANCE BRAM, a FIXED_PRI DUT,
// and an RD_LAT=1 DUT with a LOW_LATENCY BRAM. All three share one stimulus; reads are checked against a scoreboard.
module tb_c3_bram_port_arbiter;
    import c3_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;

    logic          m_gnt0, m_gnt1, m_rv0, m_rv1, m_busy, m_ena, m_wea, m_regcea, m_rsta;
    logic [AW-1:0] m_addra;
    logic [DW-1:0] m_rdata, m_dina, m_douta;
    logic          f_gnt0, f_gnt1, f_rv0, f_rv1, f_busy, f_ena, f_wea, f_regcea, f_rsta;
    logic [AW-1:0] f_addra;
    logic [DW-1:0] f_rdata, f_dina;
    wire  [DW-1:0] f_douta = '0;
    logic          l_gnt0, l_gnt1, l_rv0, l_rv1, l_busy, l_ena, l_wea, l_regcea, l_rsta;
    logic [AW-1:0] l_addra;
    logic [DW-1:0] l_rdata, l_dina, l_douta;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q_m[$];
    exp_t          q_l[$];
    logic [DW-1:0] written[int];

    always #5 clk = ~clk;

    c3_bram_port_arbiter u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(m_gnt0), .gnt1(m_gnt1), .rvalid0(m_rv0), .rvalid1(m_rv1),
        .rdata(m_rdata), .busy(m_busy), .bram_ena(m_ena), .bram_wea(m_wea),
        .bram_addra(m_addra), .bram_dina(m_dina), .bram_regcea(m_regcea),
        .bram_rsta(m_rsta), .bram_douta(m_douta)
    );

    c3_bram_port_arbiter #(.FIXED_PRI(1'b1)) u_dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rv0), .rvalid1(f_rv1),
        .rdata(f_rdata), .busy(f_busy), .bram_ena(f_ena), .bram_wea(f_wea),
        .bram_addra(f_addra), .bram_dina(f_dina), .bram_regcea(f_regcea),
        .bram_rsta(f_rsta), .bram_douta(f_douta)
    );

    c3_bram_port_arbiter #(.RD_LAT(RD_LAT_LOW_LAT)) u_dut_ll (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(l_gnt0), .gnt1(l_gnt1), .rvalid0(l_rv0), .rvalid1(l_rv1),
        .rdata(l_rdata), .busy(l_busy), .bram_ena(l_ena), .bram_wea(l_wea),
        .bram_addra(l_addra), .bram_dina(l_dina), .bram_regcea(l_regcea),
        .bram_rsta(l_rsta), .bram_douta(l_douta)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return (a == 10'd3) ? 18'h00012 : {8'h2C, a};
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return written.exists(int'(a)) ? written[int'(a)] : pattern(a);
    endfunction

    // Block RAM models: no-change write mode, preloaded on the first clock edge while reset is held.
    logic [DW-1:0] mem_m[1024];
    logic [DW-1:0] mem_l[1024];
    logic [DW-1:0] latch_m;
    logic          loaded_m = 1'b0, loaded_l = 1'b0;

    always @(posedge clk) begin
        if (!loaded_m) begin
            for (int i = 0; i < 1024; i++) mem_m[i] <= pattern(AW'(i));
            loaded_m <= 1'b1;
        end else if (m_ena) begin
            if (m_wea) mem_m[m_addra] <= m_dina;
            else       latch_m <= mem_m[m_addra];
        end
        if (!m_rsta)       m_douta <= '0;
        else if (m_regcea) m_douta <= latch_m;
    end

    always @(posedge clk) begin
        if (!loaded_l) begin
            for (int i = 0; i < 1024; i++) mem_l[i] <= pattern(AW'(i));
            loaded_l <= 1'b1;
        end else if (l_ena && l_wea) begin
            mem_l[l_addra] <= l_dina;
        end
        if (!l_rsta)                 l_douta <= '0;
        else if (l_ena && !l_wea)    l_douta <= mem_l[l_addra];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: reads are pushed when accepted and must come back exactly RD_LAT+1 cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("rst_no_rvalid", 32'({m_rv1, m_rv0, l_rv1, l_rv0}), 32'd0);
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0 && q_m[0].due == cyc) begin
                check_output("m_rvalid_tag", 32'({m_rv1, m_rv0}), (q_m[0].id == 1) ? 32'd2 : 32'd1);
                check_output("m_rdata", 32'(m_rdata), 32'(q_m[0].data));
                void'(q_m.pop_front());
            end else if (m_rv0 || m_rv1) begin
                check_output("m_rvalid_spurious", 32'({m_rv1, m_rv0}), 32'd0);
            end
            if (q_l.size() > 0 && q_l[0].due == cyc) begin
                check_output("l_rvalid_tag", 32'({l_rv1, l_rv0}), (q_l[0].id == 1) ? 32'd2 : 32'd1);
                check_output("l_rdata", 32'(l_rdata), 32'(q_l[0].data));
                check_output("l_regcea", 32'(l_regcea), 32'd0);
                void'(q_l.pop_front());
            end else if (l_rv0 || l_rv1) begin
                check_output("l_rvalid_spurious", 32'({l_rv1, l_rv0}), 32'd0);
            end
            if (req0 && m_gnt0 && !we0) q_m.push_back('{id: 0, data: model_rd(addr0), due: cyc + 3});
            if (req1 && m_gnt1 && !we1) q_m.push_back('{id: 1, data: model_rd(addr1), due: cyc + 3});
            if (req0 && l_gnt0 && !we0) q_l.push_back('{id: 0, data: model_rd(addr0), due: cyc + 2});
            if (req1 && l_gnt1 && !we1) q_l.push_back('{id: 1, data: model_rd(addr1), due: cyc + 2});
            if (req0 && m_gnt0 && we0) written[int'(addr0)] = wdata0;
            if (req1 && m_gnt1 && we1) written[int'(addr1)] = wdata1;
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic port, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
        int   n   = 0;
        logic got = 1'b0;
        if (port) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        while (!got && n < 20) begin
            @(negedge clk);
            got = port ? m_gnt1 : m_gnt0;
            n++;
        end
        check_output("gnt_within_bound", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    task automatic apply_dual(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic p1_first);
        logic g0, g1;
        logic first = 1'b1;
        int   n     = 0;
        req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1;
        while ((req0 || req1) && n < 8) begin
            @(negedge clk);
            g0 = m_gnt0;
            g1 = m_gnt1;
            if (first) check_output("dual_first_gnt", 32'({g1, g0}), p1_first ? 32'd2 : 32'd1);
            first = 1'b0;
            @(posedge clk);
            #1;
            if (g0) req0 = 1'b0;
            if (g1) req1 = 1'b0;
            n++;
        end
        check_output("dual_both_served", 32'({req0, req1}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle(3);
        check_output("reset_ena", 32'(m_ena), 32'd0);
        check_output("reset_busy", 32'(m_busy), 32'd0);
        check_output("reset_regcea", 32'(m_regcea), 32'd0);
        check_output("reset_addra", 32'(m_addra), 32'd0);
        check_output("reset_rsta", 32'(m_rsta), 32'd0);
        rst = 1'b1;
        idle(2);

        // Write then read the same address on back-to-back cycles
        apply_stimulus(1'b0, 1'b1, 10'd5, 18'h155AA);
        apply_stimulus(1'b0, 1'b0, 10'd5, '0);
        idle(6);
        check_output("drained_busy", 32'(m_busy), 32'd0);
        check_output("idle_ena", 32'(m_ena), 32'd0);
        apply_stimulus(1'b1, 1'b0, 10'd9, '0);
        idle(6);

        // Contention: grants must alternate, starting with P0
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd21;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_output("rr_gnt", 32'({m_gnt1, m_gnt0}), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            if (i % 2 == 0) addr0 = addr0 + 10'd1;
            else            addr1 = addr1 + 10'd1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        idle(6);

        // Fixed priority: P0 wins every tie; P1 is granted as soon as P0 drops out
        req0 = 1'b1; addr0 = 10'd30;
        req1 = 1'b1; addr1 = 10'd31;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("fp_gnt_tie", 32'({f_gnt1, f_gnt0}), 32'd1);
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        @(negedge clk);
        check_output("fp_gnt1_alone", 32'({f_gnt1, f_gnt0}), 32'd2);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        idle(6);

        // Write by P0 interleaved with a read by P1, then read back the written word
        apply_dual(1'b1, 10'd7, 18'h3FFFF, 1'b0, 10'd3, '0, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 1'b0, 10'd7, '0);
        idle(6);

        // Reset while two reads are in flight
        apply_stimulus(1'b1, 1'b0, 10'd5, '0);
        apply_stimulus(1'b0, 1'b0, 10'd7, '0);
        rst = 1'b0;
        #1;
        check_output("midrst_ena", 32'(m_ena), 32'd0);
        check_output("midrst_busy", 32'({m_busy, l_busy}), 32'd0);
        check_output("midrst_rvalid", 32'({m_rv1, m_rv0}), 32'd0);
        idle(3);
        rst = 1'b1;
        idle(5);
        apply_dual(1'b0, 10'd5, '0, 1'b0, 10'd7, '0, 1'b0);
        idle(6);

        // Single read, which the RD_LAT=1 build returns one cycle earlier
        apply_stimulus(1'b0, 1'b0, 10'd3, '0);
        idle(6);

        check_output("m_sb_empty", 32'(q_m.size()), 32'd0);
        check_output("l_sb_empty", 32'(q_l.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
